// File: rtl/map_bus_arbiter.sv
// map_bus_arbiter: debounced, locked, conflict-checked mux of N_CH mapper channels onto the shared CPU/ROM/BSRAM buses
module map_bus_arbiter #(
    parameter int              N_CH          = 6,
    parameter int              ROM_AW        = 24,
    parameter int              RAM_AW        = 20,
    parameter int              SETTLE_CYCLES = 16,
    parameter int              REG_OUT       = 0,
    parameter logic [N_CH-1:0] TURBO_DENY    = N_CH'(6'b001010)
) (
    input  logic                        MCLK,
    input  logic                        RESET_N,
    input  logic                        RELOCK,
    input  logic [N_CH-2:0]             MAP_ACTIVE,
    input  logic [8*N_CH-1:0]           CH_DO,
    input  logic [N_CH-1:0]             CH_IRQ_N,
    input  logic [ROM_AW*N_CH-1:0]      CH_ROM_ADDR,
    input  logic [N_CH-1:0]             CH_ROM_CE_N,
    input  logic [N_CH-1:0]             CH_ROM_OE_N,
    input  logic [N_CH-1:0]             CH_ROM_WORD,
    input  logic [RAM_AW*N_CH-1:0]      CH_BSRAM_ADDR,
    input  logic [8*N_CH-1:0]           CH_BSRAM_D,
    input  logic [N_CH-1:0]             CH_BSRAM_CE_N,
    input  logic [N_CH-1:0]             CH_BSRAM_OE_N,
    input  logic [N_CH-1:0]             CH_BSRAM_WE_N,
    output logic [7:0]                  DI,
    output logic                        IRQ_N,
    output logic [ROM_AW-1:0]           ROM_ADDR,
    output logic                        ROM_CE_N,
    output logic                        ROM_OE_N,
    output logic                        ROM_WORD,
    output logic [RAM_AW-1:0]           BSRAM_ADDR,
    output logic [7:0]                  BSRAM_D,
    output logic                        BSRAM_CE_N,
    output logic                        BSRAM_OE_N,
    output logic                        BSRAM_WE_N,
    output logic [$clog2(N_CH)-1:0]     SEL,
    output logic                        LOCKED,
    output logic                        CONFLICT,
    output logic                        TURBO_ALLOW
);
    localparam int SW = $clog2(N_CH);
    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic {SETTLE, LOCK} state_t;

    typedef struct packed {
        logic [7:0]        di;
        logic              irq_n;
        logic [ROM_AW-1:0] rom_addr;
        logic              rom_ce_n;
        logic              rom_oe_n;
        logic              rom_word;
        logic [RAM_AW-1:0] bsram_addr;
        logic [7:0]        bsram_d;
        logic              bsram_ce_n;
        logic              bsram_oe_n;
        logic              bsram_we_n;
    } bus_t;

    localparam bus_t IDLE = '{di: 8'h00, irq_n: 1'b1, rom_addr: '0, rom_ce_n: 1'b1,
                              rom_oe_n: 1'b1, rom_word: 1'b0, bsram_addr: '0, bsram_d: 8'h00,
                              bsram_ce_n: 1'b1, bsram_oe_n: 1'b1, bsram_we_n: 1'b1};

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [N_CH-2:0] snap_q, snap_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            conflict_q, conflict_d;
    int              n_req;
    logic [SW-1:0]   req_idx;
    bus_t            mux_c;
    bus_t            bus;

    // Decode the settled snapshot: count requests and remember the highest requester
    always_comb begin
        n_req   = 0;
        req_idx = '0;
        for (int i = 1; i < N_CH; i++) begin
            if (snap_q[i-1]) begin
                n_req   = n_req + 1;
                req_idx = SW'(i);
            end
        end
    end

    // Next state: RELOCK dominates; SETTLE debounces MAP_ACTIVE and locks once stable long enough
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        sel_d      = sel_q;
        conflict_d = conflict_q;
        if (RELOCK) begin
            state_d = SETTLE;
            cnt_d   = 8'd0;
            snap_d  = MAP_ACTIVE;
        end else if (state_q == SETTLE) begin
            if (MAP_ACTIVE != snap_q) begin
                snap_d = MAP_ACTIVE;
                cnt_d  = 8'd0;
            end else begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d    = LOCK;
                    sel_d      = (n_req == 1) ? req_idx : '0;
                    conflict_d = conflict_q | (n_req > 1);
                end
            end
        end
    end

    // Control state registers
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= SETTLE;
            cnt_q      <= 8'd0;
            snap_q     <= '0;
            sel_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            sel_q      <= sel_d;
            conflict_q <= conflict_d;
        end
    end

    // Bus mux: locked channel's slices in LOCK, idle values otherwise
    always_comb begin
        mux_c = IDLE;
        if (state_q == LOCK) begin
            for (int k = 0; k < N_CH; k++) begin
                if (sel_q == SW'(k)) begin
                    mux_c.di         = CH_DO[8*k +: 8];
                    mux_c.irq_n      = CH_IRQ_N[k];
                    mux_c.rom_addr   = CH_ROM_ADDR[ROM_AW*k +: ROM_AW];
                    mux_c.rom_ce_n   = CH_ROM_CE_N[k];
                    mux_c.rom_oe_n   = CH_ROM_OE_N[k];
                    mux_c.rom_word   = CH_ROM_WORD[k];
                    mux_c.bsram_addr = CH_BSRAM_ADDR[RAM_AW*k +: RAM_AW];
                    mux_c.bsram_d    = CH_BSRAM_D[8*k +: 8];
                    mux_c.bsram_ce_n = CH_BSRAM_CE_N[k];
                    mux_c.bsram_oe_n = CH_BSRAM_OE_N[k];
                    mux_c.bsram_we_n = CH_BSRAM_WE_N[k];
                end
            end
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            bus_t bus_q;
            // Optional output stage; resets straight to idle so reset still clears the bus at once
            always_ff @(posedge MCLK or negedge RESET_N) begin
                if (!RESET_N) bus_q <= IDLE;
                else          bus_q <= mux_c;
            end
            assign bus = bus_q;
        end else begin : g_comb
            assign bus = mux_c;
        end
    endgenerate

    assign DI          = bus.di;
    assign IRQ_N       = bus.irq_n;
    assign ROM_ADDR    = bus.rom_addr;
    assign ROM_CE_N    = bus.rom_ce_n;
    assign ROM_OE_N    = bus.rom_oe_n;
    assign ROM_WORD    = bus.rom_word;
    assign BSRAM_ADDR  = bus.bsram_addr;
    assign BSRAM_D     = bus.bsram_d;
    assign BSRAM_CE_N  = bus.bsram_ce_n;
    assign BSRAM_OE_N  = bus.bsram_oe_n;
    assign BSRAM_WE_N  = bus.bsram_we_n;
    assign SEL         = sel_q;
    assign LOCKED      = (state_q == LOCK);
    assign CONFLICT    = conflict_q;
    assign TURBO_ALLOW = (state_q == LOCK) & ~TURBO_DENY[sel_q];
endmodule
